tmds_timing_gen: RTL
====================

Name: tmds_timing_gen

Overview:
- Transmit-side video timing generator for the TMDS/HDMI output path.
- Free-running H/V counters produce hsync, vsync and video_en for the TMDS encoder.
- Pulls pixels from the line FIFO with a one-cycle-ahead read strobe and presents pixel data aligned with video_en.
- Defaults are 1280x720p60 (1650x750 total); starts and stops only on frame boundaries.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync asserted level
- VS_POL, 1, vsync asserted level
- DATA_W, 24, pixel width (RGB888)

Ports:
- tx0_pclk  in  1  pixel clock; all logic on rising edge
- rstbtn_n  in  1  synchronous reset, active low
- enable  in  1  run request
- fifo_empty  in  1  line FIFO empty
- fifo_dout  in  DATA_W  FIFO read data, valid one cycle after fifo_rd_en
- fifo_rd_en  out  1  FIFO read strobe
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_en  out  1  data enable (active region)
- pix_data  out  DATA_W  pixel, aligned with video_en
- video_hcnt  out  11  active-region x, aligned with video_en
- video_vcnt  out  11  active-region y, aligned with video_en
- frame_start  out  1  one-cycle pulse coincident with first video_en of a frame
- underflow  out  1  sticky: read attempted while FIFO empty
- busy  out  1  state is RUN

Behaviour:
- Reset (rstbtn_n=0 at clock edge):
  - state=IDLE; counters hc=vc=0.
  - fifo_rd_en, video_en, frame_start, underflow, busy = 0.
  - pix_data, video_hcnt, video_vcnt = 0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - Reset mid-frame aborts immediately; no partial line completes.
- Counters (stage 0, 11-bit):
  - In RUN, hc counts 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP.
  - On hc wrap, vc counts 0..V_TOTAL-1, then wraps to 0.
  - In IDLE, hc and vc are held at 0.
- Region decodes (stage 0):
  - act = hc<H_ACTIVE && vc<V_ACTIVE.
  - hs = H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, whole lines, transitions at hc=0.
- FSM:
  - IDLE -> RUN when enable=1. The first RUN cycle has hc=vc=0.
  - RUN -> IDLE only when enable=0 is sampled at hc=H_TOTAL-1 and vc=V_TOTAL-1.
  - enable deassert mid-frame is ignored until the frame ends; no truncated frames.
  - enable re-asserted before the frame end keeps RUN with no gap.
- Pipeline:
  - Stage 1 (one cycle after stage 0): fifo_rd_en = act & RUN.
  - Stage 2 (two cycles after stage 0): hsync, vsync, video_en, video_hcnt, video_vcnt, frame_start are registered stage-0 values delayed two cycles.
  - pix_data = fifo_dout captured in stage 2.
  - video_en lags fifo_rd_en by exactly 1 cycle.
  - hsync/vsync drive asserted level HS_POL/VS_POL when hs/vs is true, else the inverse.
- video_hcnt/video_vcnt: equal hc/vc during video_en; 0 outside active.
- frame_start: asserted for the stage-2 image of hc=0, vc=0.
- Underflow:
  - If fifo_rd_en=1 while fifo_empty=1, pix_data for that slot is forced to 0.
  - underflow sets and stays 1 until reset.
  - Timing is never stalled by underflow.
- Return to IDLE: pipeline drains over 2 cycles. Outputs return to reset levels; these are also the end-of-frame levels.

Test Plan:
- Small params (H 8/2/3/3, total 16; V 4/1/2/1, total 8), enable=1 after reset, FIFO never empty, RUN entered at cycle T0:
  - fifo_rd_en high for T0+1..T0+8.
  - video_en high for T0+2..T0+9 with video_hcnt 0..7.
  - hsync high for T0+12..T0+14.
  - Line period 16 cycles; frame period 128 cycles.
- Same params, vsync and frame_start:
  - vsync high for lines 5-6 (output cycles T0+82..T0+113).
  - frame_start pulses at T0+2 and T0+130.
  - No other pulses.
- enable dropped at T0+40 (mid-frame):
  - Frame completes.
  - busy falls after cycle T0+127.
  - Outputs idle from T0+130.
  - Next enable restarts at hc=vc=0.
- fifo_empty=1 for a single read in line 2, pixel 3:
  - That pixel outputs 0; neighbours output fifo_dout.
  - underflow=1 and remains set.
- rstbtn_n=0 for one cycle mid-line 1:
  - Next cycle all outputs at reset values, hsync=vsync=0 (HS_POL=VS_POL=1).
  - Restart timing identical to the first scenario.
- Default 720p params:
  - Per line: 1280 video_en cycles, hsync 40 cycles starting 1390 cycles after video_en rise, line period 1650.
  - Per frame: 720 active lines, vsync on lines 725-729, frame period 1,237,500 cycles.

Source files
------------

// File: rtl/tmds_timing_gen_if.sv
// Video-side signal bundle between the TMDS timing generator, its line FIFO and the encoder.
// The master modport is the timing generator. The slave modport is the FIFO/encoder side.
interface tmds_timing_gen_if #(
   parameter int unsigned DATA_W = 24
);
   logic              enable;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_rd_en;
   logic              hsync;
   logic              vsync;
   logic              video_en;
   logic [DATA_W-1:0] pix_data;
   logic [10:0]       video_hcnt;
   logic [10:0]       video_vcnt;
   logic              frame_start;
   logic              underflow;
   logic              busy;

   modport master (
      input  enable, fifo_empty, fifo_dout,
      output fifo_rd_en, hsync, vsync, video_en, pix_data, video_hcnt, video_vcnt,
             frame_start, underflow, busy
   );

   modport slave (
      output enable, fifo_empty, fifo_dout,
      input  fifo_rd_en, hsync, vsync, video_en, pix_data, video_hcnt, video_vcnt,
             frame_start, underflow, busy
   );
endinterface

// File: rtl/tmds_timing_gen.sv
// Transmit-side video timing generator. Free-running H/V counters (stage 0) feed a FIFO read
// strobe (stage 1) and registered sync/enable/coordinates (stage 2). Starts and stops only on
// frame boundaries.
module tmds_timing_gen #(
   parameter int unsigned H_ACTIVE = 1280,
   parameter int unsigned H_FP     = 110,
   parameter int unsigned H_SYNC   = 40,
   parameter int unsigned H_BP     = 220,
   parameter int unsigned V_ACTIVE = 720,
   parameter int unsigned V_FP     = 5,
   parameter int unsigned V_SYNC   = 5,
   parameter int unsigned V_BP     = 20,
   parameter bit          HS_POL   = 1'b1,
   parameter bit          VS_POL   = 1'b1,
   parameter int unsigned DATA_W   = 24
) (
   input logic                tx0_pclk,
   input logic                rstbtn_n,
   tmds_timing_gen_if.master  io_tmds
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] HC_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] VC_LAST = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e      r_state;
   state_e      w_state_nxt;
   logic [10:0] r_hc, r_vc;
   logic [10:0] w_hc_nxt, w_vc_nxt;

   logic w_run, w_act, w_hs, w_vs, w_fs;

   // Stage 1
   logic        r_rd_en;
   logic        r_act1, r_hs1, r_vs1, r_fs1;
   logic [10:0] r_hc1, r_vc1;

   // Stage 2
   logic        r_hsync, r_vsync, r_video_en, r_frame_start;
   logic [10:0] r_hcnt, r_vcnt;
   logic        r_slot_empty;
   logic        r_underflow;

   // State and counter registers
   always_ff @(posedge tx0_pclk) begin
      if (!rstbtn_n) begin
         r_state <= StIdle;
         r_hc    <= '0;
         r_vc    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_hc    <= w_hc_nxt;
         r_vc    <= w_vc_nxt;
      end
   end

   // Next state and counter advance; IDLE holds counters at the frame origin
   always_comb begin
      w_state_nxt = r_state;
      w_hc_nxt    = '0;
      w_vc_nxt    = '0;
      unique case (r_state)
         StIdle: begin
            if (io_tmds.enable) begin
               w_state_nxt = StRun;
            end
         end
         StRun: begin
            if (r_hc == HC_LAST) begin
               if (r_vc == VC_LAST) begin
                  // Frame boundary: the only point where a stop request is honoured
                  if (!io_tmds.enable) begin
                     w_state_nxt = StIdle;
                  end
               end else begin
                  w_vc_nxt = r_vc + 11'd1;
               end
            end else begin
               w_hc_nxt = r_hc + 11'd1;
               w_vc_nxt = r_vc;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   assign w_run = (r_state == StRun);
   assign w_act = w_run && (r_hc < H_ACT) && (r_vc < V_ACT);
   assign w_hs  = w_run && (r_hc >= HS_BEG) && (r_hc < HS_END);
   assign w_vs  = w_run && (r_vc >= VS_BEG) && (r_vc < VS_END);
   assign w_fs  = w_run && (r_hc == '0) && (r_vc == '0);

   // Stage 1: FIFO read strobe one cycle ahead of the data enable
   always_ff @(posedge tx0_pclk) begin
      if (!rstbtn_n) begin
         r_rd_en <= 1'b0;
         r_act1  <= 1'b0;
         r_hs1   <= 1'b0;
         r_vs1   <= 1'b0;
         r_fs1   <= 1'b0;
         r_hc1   <= '0;
         r_vc1   <= '0;
      end else begin
         r_rd_en <= w_act;
         r_act1  <= w_act;
         r_hs1   <= w_hs;
         r_vs1   <= w_vs;
         r_fs1   <= w_fs;
         r_hc1   <= w_act ? r_hc : '0;
         r_vc1   <= w_act ? r_vc : '0;
      end
   end

   // Stage 2: encoder-facing timing, plus underflow bookkeeping for the slot just read
   always_ff @(posedge tx0_pclk) begin
      if (!rstbtn_n) begin
         r_hsync       <= ~HS_POL;
         r_vsync       <= ~VS_POL;
         r_video_en    <= 1'b0;
         r_frame_start <= 1'b0;
         r_hcnt        <= '0;
         r_vcnt        <= '0;
         r_slot_empty  <= 1'b0;
         r_underflow   <= 1'b0;
      end else begin
         r_hsync       <= r_hs1 ? HS_POL : ~HS_POL;
         r_vsync       <= r_vs1 ? VS_POL : ~VS_POL;
         r_video_en    <= r_act1;
         r_frame_start <= r_fs1;
         r_hcnt        <= r_hc1;
         r_vcnt        <= r_vc1;
         r_slot_empty  <= r_rd_en & io_tmds.fifo_empty;
         r_underflow   <= r_underflow | (r_rd_en & io_tmds.fifo_empty);
      end
   end

   // FIFO data arrives in the cycle after the strobe, i.e. the stage-2 cycle, so it is gated
   // here rather than registered again; an empty-slot read is blanked to black.
   assign io_tmds.pix_data    = (r_video_en && !r_slot_empty) ? io_tmds.fifo_dout : '0;
   assign io_tmds.fifo_rd_en  = r_rd_en;
   assign io_tmds.hsync       = r_hsync;
   assign io_tmds.vsync       = r_vsync;
   assign io_tmds.video_en    = r_video_en;
   assign io_tmds.video_hcnt  = r_hcnt;
   assign io_tmds.video_vcnt  = r_vcnt;
   assign io_tmds.frame_start = r_frame_start;
   assign io_tmds.underflow   = r_underflow;
   assign io_tmds.busy        = w_run;

endmodule
